// File: rtl/pipe_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the in-order pipeline control slice.
//   NUM_STAGES  : number of pipeline stages (0 = IF youngest, NUM_STAGES-1 = WB)
//   ST_*        : stage index constants
//   NOP_INSTR   : instruction word loaded by a pipeline register when bubbled
//   stage_vec_t : one bit per stage
//   suffix_or() : bit i = OR of bits i..NUM_STAGES-1 (stage i or anything older)
// ----------------------------------------------------------------------------
package pipe_pkg;

   localparam int NUM_STAGES = 5;

   localparam int ST_IF  = 0;
   localparam int ST_ID  = 1;
   localparam int ST_EX  = 2;
   localparam int ST_MEM = 3;
   localparam int ST_WB  = 4;

   // addi x0, x0, 0 -- the canonical NOP that bubble muxes insert
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef logic [NUM_STAGES-1:0] stage_vec_t;

   // Older-to-younger propagation: a request at stage i affects stage i and
   // every younger stage, so each bit collects its own and all older bits.
   function automatic stage_vec_t suffix_or(input stage_vec_t v);
      stage_vec_t m;
      logic       acc;
      acc = 1'b0;
      m   = '0;
      for (int i = NUM_STAGES - 1; i >= 0; i--) begin
         acc  = acc | v[i];
         m[i] = acc;
      end
      return m;
   endfunction

endpackage

// File: rtl/stall_watchdog.sv
// ----------------------------------------------------------------------------
// stall_watchdog
// Counts consecutive cycles in which the front of the pipeline is frozen and
// raises a sticky timeout once the run length reaches WDOG_CYC.
//   clk, rst_n     : clock / asynchronous active-low reset
//   advance        : stage 0 loads this cycle (clears the run counter)
//   wdog_clr       : clears the sticky timeout (a same-cycle set wins)
//   stall_cnt      : current run length, saturating at all-ones
//   stall_timeout  : sticky watchdog flag
// ----------------------------------------------------------------------------
module stall_watchdog #(
   parameter int WDOG_CYC = 64,
   parameter int CNT_W    = $clog2(WDOG_CYC + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             advance,
   input  logic             wdog_clr,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             stall_timeout
);

   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] WDOG_VAL = CNT_W'(WDOG_CYC);

   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             timeout_reg, timeout_next;
   logic             wdog_hit;

   always_comb begin
      cnt_next = cnt_reg;
      if (advance) begin
         cnt_next = '0;
      end else if (cnt_reg != CNT_MAX) begin
         cnt_next = cnt_reg + CNT_W'(1);
      end
   end

   // Fire only on the transition onto WDOG_VAL so a counter parked at
   // saturation (when WDOG_CYC equals the max) does not re-arm after a clear.
   assign wdog_hit     = !advance && (cnt_next == WDOG_VAL) && (cnt_reg != WDOG_VAL);
   assign timeout_next = wdog_hit | (timeout_reg & !wdog_clr);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg     <= '0;
         timeout_reg <= 1'b0;
      end else begin
         cnt_reg     <= cnt_next;
         timeout_reg <= timeout_next;
      end
   end

   assign stall_cnt     = cnt_reg;
   assign stall_timeout = timeout_reg;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Per-stage hold/advance and bubble control for an in-order pipeline.
//   clk, rst_n     : clock / asynchronous active-low reset
//   stall_req      : level, bit i = stage i cannot complete this cycle
//   flush_req      : pulse, bit k = stage k redirects and kills stages 0..k-1
//   lu_hazard      : pulse from decode, starts an LU_STALL_CYC-cycle freeze of
//                    stages 0..LU_STAGE (ignored while one is in progress)
//   wdog_clr       : clears the sticky stall_timeout
//   stage_en       : bit i = stage i register loads (bit 0 = PC write)
//   bubble         : bit i = stage i loads a NOP instead of stage i-1 data
//   pc_write       : stage_en[0]
//   stall_active   : any stage frozen this cycle (after flush override)
//   stall_cnt      : consecutive frozen cycles of stage 0 (saturating)
//   stall_timeout  : sticky watchdog flag
// All outputs are combinational from the inputs plus registered state.
// While rst_n is low the outputs are forced to a safe "all bubble" pattern.
// ----------------------------------------------------------------------------
module pipeline_hazard_ctrl
   import pipe_pkg::*;
#(
   parameter int  LU_STAGE     = ST_ID,
   parameter int  LU_STALL_CYC = 1,
   parameter int  WDOG_CYC     = 64,
   localparam int CNT_W        = $clog2(WDOG_CYC + 1)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_STAGES-1:0] stall_req,
   input  logic [NUM_STAGES-1:0] flush_req,
   input  logic                  lu_hazard,
   input  logic                  wdog_clr,
   output logic [NUM_STAGES-1:0] stage_en,
   output logic [NUM_STAGES-1:0] bubble,
   output logic                  pc_write,
   output logic                  stall_active,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic                  stall_timeout
);

   // lu_cnt holds the remaining stall cycles after the current one, so its
   // largest value is LU_STALL_CYC-1.
   localparam int LU_W = (LU_STALL_CYC > 1) ? $clog2(LU_STALL_CYC) : 1;

   logic [LU_W-1:0] lu_cnt_reg, lu_cnt_next;
   logic            lu_idle;
   logic            lu_cancel;
   logic            lu_active;

   stage_vec_t stall_older;   // bit i: stage i or an older stage is stalled
   stage_vec_t flush_kill;    // bit j: some stage older than j redirects
   stage_vec_t frz;           // freeze before the flush override
   stage_vec_t en_int;
   stage_vec_t bub_int;

   assign stall_older = suffix_or(stall_req);
   // Shifting the suffix-OR down by one excludes the redirecting stage itself:
   // a flush at k kills strictly younger stages, and the oldest k dominates.
   assign flush_kill  = suffix_or(flush_req) >> 1;

   assign lu_idle   = (lu_cnt_reg == '0);
   // A redirect from beyond the consumer stage makes the dependent
   // instruction dead, so the load-use stall is abandoned this same cycle.
   assign lu_cancel = flush_kill[LU_STAGE];
   assign lu_active = !lu_cancel && (!lu_idle || lu_hazard);

   always_comb begin
      lu_cnt_next = lu_cnt_reg;
      if (lu_cancel) begin
         lu_cnt_next = '0;
      end else if (!lu_idle) begin
         lu_cnt_next = lu_cnt_reg - LU_W'(1);
      end else if (lu_hazard) begin
         lu_cnt_next = LU_W'(LU_STALL_CYC - 1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lu_cnt_reg <= '0;
      end else begin
         lu_cnt_reg <= lu_cnt_next;
      end
   end

   // Per-stage freeze / flush priority network.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
         logic normal_bub;

         if (gi <= LU_STAGE) begin : g_lu
            assign frz[gi] = stall_older[gi] | lu_active;
         end else begin : g_nolu
            assign frz[gi] = stall_older[gi];
         end

         // A stage that advances while its younger neighbour holds would
         // otherwise re-capture that neighbour's (stale) data: insert a NOP.
         if (gi == 0) begin : g_first
            assign normal_bub = 1'b0;
         end else begin : g_rest
            assign normal_bub = frz[gi-1] & ~frz[gi];
         end

         // A killed stage loads a NOP unconditionally, overriding any freeze.
         assign en_int[gi]  = flush_kill[gi] | ~frz[gi];
         assign bub_int[gi] = flush_kill[gi] | normal_bub;
      end
   endgenerate

   assign stage_en     = rst_n ? en_int  : '0;
   assign bubble       = rst_n ? bub_int : '1;
   assign pc_write     = stage_en[ST_IF];
   assign stall_active = rst_n & (|(frz & ~flush_kill));

   stall_watchdog #(
      .WDOG_CYC (WDOG_CYC),
      .CNT_W    (CNT_W)
   ) u_stall_watchdog (
      .clk           (clk),
      .rst_n         (rst_n),
      .advance       (stage_en[ST_IF]),
      .wdog_clr      (wdog_clr),
      .stall_cnt     (stall_cnt),
      .stall_timeout (stall_timeout)
   );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed scenarios followed by randomized traffic, every cycle compared
// against a cycle-indexed behavioural model of the hazard rules.
// ----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;
   import pipe_pkg::*;

   localparam int LU_STG = 1;
   localparam int LU_CYC = 2;
   localparam int WDOG   = 64;
   localparam int CNT_W  = $clog2(WDOG + 1);
   localparam int CNT_SAT = (1 << CNT_W) - 1;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NUM_STAGES-1:0] stall_req = '0;
   logic [NUM_STAGES-1:0] flush_req = '0;
   logic                  lu_hazard = 1'b0;
   logic                  wdog_clr = 1'b0;
   logic [NUM_STAGES-1:0] stage_en;
   logic [NUM_STAGES-1:0] bubble;
   logic                  pc_write;
   logic                  stall_active;
   logic [CNT_W-1:0]      stall_cnt;
   logic                  stall_timeout;

   pipeline_hazard_ctrl #(
      .LU_STAGE     (LU_STG),
      .LU_STALL_CYC (LU_CYC),
      .WDOG_CYC     (WDOG)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .stall_req     (stall_req),
      .flush_req     (flush_req),
      .lu_hazard     (lu_hazard),
      .wdog_clr      (wdog_clr),
      .stage_en      (stage_en),
      .bubble        (bubble),
      .pc_write      (pc_write),
      .stall_active  (stall_active),
      .stall_cnt     (stall_cnt),
      .stall_timeout (stall_timeout)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Model state: cycle index, cycle at which the load-use freeze ends
   // (exclusive), run length of stage-0 freeze, sticky timeout.
   int cyc    = 0;
   int lu_end = 0;
   int run    = 0;
   bit to_m   = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s cyc=%0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // One clock cycle: drive inputs after the falling edge, check outputs 1ns
   // later, then advance the model to the state the rising edge will create.
   task automatic step(input logic [4:0] sr, input logic [4:0] fr,
                       input logic lh, input logic wc, input logic rn);
      logic [4:0] e_en;
      logic [4:0] e_bub;
      logic [4:0] fz;
      bit         e_sa;
      bit         cancel;
      bit         lu_on;
      bit         set;
      int         k;
      int         oldest;
      int         e_cnt;

      @(negedge clk);
      stall_req = sr;
      flush_req = fr;
      lu_hazard = lh;
      wdog_clr  = wc;
      rst_n     = rn;
      #1;

      cancel = 1'b0;
      if (!rn) begin
         run    = 0;
         to_m   = 1'b0;
         lu_end = 0;
         e_en   = 5'b00000;
         e_bub  = 5'b11111;
         e_sa   = 1'b0;
      end else begin
         k = -1;
         oldest = -1;
         for (int i = 0; i < NUM_STAGES; i++) begin
            if (fr[i]) k = i;
            if (sr[i]) oldest = i;
         end
         cancel = (k > LU_STG);
         lu_on  = !cancel && ((cyc < lu_end) || lh);
         for (int i = 0; i < NUM_STAGES; i++) begin
            fz[i] = (i <= oldest) || (lu_on && (i <= LU_STG));
         end
         e_sa = 1'b0;
         for (int i = 0; i < NUM_STAGES; i++) begin
            if (i < k) begin
               e_en[i]  = 1'b1;
               e_bub[i] = 1'b1;
            end else begin
               e_en[i]  = !fz[i];
               e_bub[i] = (i > 0) && fz[i-1] && !fz[i];
               if (fz[i]) e_sa = 1'b1;
            end
         end
      end
      e_cnt = (run > CNT_SAT) ? CNT_SAT : run;

      chk("stage_en",      32'(stage_en),      32'(e_en));
      chk("bubble",        32'(bubble),        32'(e_bub));
      chk("pc_write",      32'(pc_write),      32'(e_en[0]));
      chk("stall_active",  32'(stall_active),  32'(e_sa));
      chk("stall_cnt",     32'(stall_cnt),     32'(e_cnt));
      chk("stall_timeout", 32'(stall_timeout), 32'(to_m));

      $display("cyc=%0d rst_n=%b sr=%b fr=%b lh=%b wc=%b -> en=%b bub=%b sa=%b cnt=%0d to=%b",
               cyc, rn, sr, fr, lh, wc, stage_en, bubble, stall_active, stall_cnt, stall_timeout);

      if (rn) begin
         if (cancel) begin
            lu_end = cyc;
         end else if (lh && (cyc >= lu_end)) begin
            lu_end = cyc + LU_CYC;
         end
         set = !e_en[0] && (run + 1 == WDOG);
         if (e_en[0]) run = 0;
         else         run = run + 1;
         if (set)     to_m = 1'b1;
         else if (wc) to_m = 1'b0;
      end
      cyc++;
   endtask

   initial begin
      logic [4:0] sr;
      logic [4:0] fr;

      // Reset: forced outputs
      step(5'b0, 5'b0, 1'b0, 1'b0, 1'b0);
      chk("rst_en",  32'(stage_en), 32'h00);
      chk("rst_bub", 32'(bubble),   32'h1f);
      step(5'b0, 5'b0, 1'b0, 1'b0, 1'b0);

      // 1. Idle
      step(5'b0, 5'b0, 1'b0, 1'b0, 1'b1);
      step(5'b0, 5'b0, 1'b0, 1'b0, 1'b1);
      chk("idle_en",  32'(stage_en), 32'h1f);
      chk("idle_bub", 32'(bubble),   32'h00);

      // 2. MEM stall for three cycles
      step(5'b01000, 5'b0, 1'b0, 1'b0, 1'b1);
      chk("mem_en",  32'(stage_en), 32'b10000);
      chk("mem_bub", 32'(bubble),   32'b10000);
      step(5'b01000, 5'b0, 1'b0, 1'b0, 1'b1);
      step(5'b01000, 5'b0, 1'b0, 1'b0, 1'b1);
      step(5'b00000, 5'b0, 1'b0, 1'b0, 1'b1);
      chk("mem_cnt3", 32'(stall_cnt), 32'd3);
      step(5'b00000, 5'b0, 1'b0, 1'b0, 1'b1);
      chk("mem_cnt0", 32'(stall_cnt), 32'd0);

      // 3. Load-use stall, second pulse ignored
      step(5'b0, 5'b0, 1'b1, 1'b0, 1'b1);
      chk("lu0_en",  32'(stage_en), 32'b11100);
      chk("lu0_bub", 32'(bubble),   32'b00100);
      step(5'b0, 5'b0, 1'b1, 1'b0, 1'b1);
      chk("lu1_en",  32'(stage_en), 32'b11100);
      step(5'b0, 5'b0, 1'b0, 1'b0, 1'b1);
      chk("lu2_en",  32'(stage_en), 32'b11111);

      // 4. Flush from EX cancels load-use
      step(5'b0, 5'b00100, 1'b1, 1'b0, 1'b1);
      chk("fl_lu_en",  32'(stage_en), 32'b11111);
      chk("fl_lu_bub", 32'(bubble),   32'b00011);
      step(5'b0, 5'b0, 1'b0, 1'b0, 1'b1);
      chk("fl_lu_nxt", 32'(stage_en), 32'b11111);

      // 5. Flush from MEM over WB stall
      step(5'b10000, 5'b01000, 1'b0, 1'b0, 1'b1);
      chk("fl_st_en",  32'(stage_en), 32'b00111);
      chk("fl_st_bub", 32'(bubble),   32'b00111);
      step(5'b0, 5'b0, 1'b0, 1'b0, 1'b1);

      // 6. Watchdog
      for (int i = 0; i < 70; i++) step(5'b10000, 5'b0, 1'b0, 1'b0, 1'b1);
      chk("wd_set", 32'(stall_timeout), 32'd1);
      step(5'b0, 5'b0, 1'b0, 1'b0, 1'b1);
      chk("wd_hold", 32'(stall_timeout), 32'd1);
      step(5'b0, 5'b0, 1'b0, 1'b1, 1'b1);
      step(5'b0, 5'b0, 1'b0, 1'b0, 1'b1);
      chk("wd_clr", 32'(stall_timeout), 32'd0);
      for (int i = 0; i < 10; i++) step(5'b10000, 5'b0, 1'b0, 1'b0, 1'b1);
      step(5'b10000, 5'b0, 1'b0, 1'b0, 1'b0);
      chk("wd_rst_cnt", 32'(stall_cnt), 32'd0);
      step(5'b00000, 5'b0, 1'b0, 1'b0, 1'b1);
      chk("post_rst_en", 32'(stage_en), 32'h1f);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         sr = '0;
         fr = '0;
         for (int b = 0; b < NUM_STAGES; b++) begin
            if ($urandom_range(0, 7) == 0) sr[b] = 1'b1;
         end
         if ($urandom_range(0, 9) == 0) fr[$urandom_range(0, NUM_STAGES - 1)] = 1'b1;
         if ($urandom_range(0, 19) == 0) fr[$urandom_range(0, NUM_STAGES - 1)] = 1'b1;
         step(sr, fr, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
              ($urandom_range(0, 149) != 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
